// File: rtl/game_ctrl_if.sv
// Renderer-facing control bundle for game_ctrl: frame/go/pixel results in, road controls out.
// master drives the inputs (renderer/bench side); slave is the controller.
interface game_ctrl_if;
    logic        frame;
    logic        go;
    logic        car_px;
    logic        on_road;
    logic        setup;
    logic        drive;
    logic        flash;
    logic        flash_car;
    logic [2:0]  size;
    logic [15:0] score;
    logic [1:0]  state_o;

    modport master (
        output frame, go, car_px, on_road,
        input  setup, drive, flash, flash_car, size, score, state_o
    );

    modport slave (
        input  frame, go, car_px, on_road,
        output setup, drive, flash, flash_car, size, score, state_o
    );
endinterface

// File: rtl/game_ctrl.sv
// Game-flow FSM for the driving game: road setup/scroll control, per-frame crash detection, flash.
// Define GAME_SCORE_EN to build the 16-bit survival score counter; otherwise score reads 0.
module game_ctrl #(
    parameter int unsigned GRACE_FRAMES  = 32,
    parameter int unsigned SHRINK_FRAMES = 256,
    parameter int unsigned FLASH_FRAMES  = 16,
    parameter int unsigned CRASH_FRAMES  = 128,
    parameter logic [2:0]  SIZE_MAX      = 3'd7,
    parameter logic [2:0]  SIZE_MIN      = 3'd2
) (
    input logic        clk,
    input logic        reset,
    game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StSetup = 2'd0,
        StReady = 2'd1,
        StDrive = 2'd2,
        StCrash = 2'd3
    } state_t;

    localparam logic [15:0] GraceCnt  = 16'(GRACE_FRAMES);
    localparam logic [15:0] ShrinkCnt = 16'(SHRINK_FRAMES);
    localparam logic [15:0] FlashCnt  = 16'(FLASH_FRAMES);
    localparam logic [15:0] CrashCnt  = 16'(CRASH_FRAMES);

    state_t      r_state, w_state_d;
    logic        r_go_q;
    logic        w_go_rise;
    logic        r_crash_flag, w_crash_flag_d, w_crash_now;
    logic [15:0] r_fcnt, w_fcnt_d;
    logic [15:0] r_pcnt, w_pcnt_d, w_pcnt_inc;
    logic        r_flash, w_flash_d;
    logic [2:0]  r_size, w_size_d;
    logic        r_setup, r_drive, r_flash_car;

    assign w_go_rise  = bus.go & ~r_go_q;
    // A violation on the frame-pulse cycle still belongs to the frame that is ending.
    assign w_crash_now    = r_crash_flag | (bus.car_px & ~bus.on_road);
    assign w_crash_flag_d = bus.frame ? 1'b0 : w_crash_now;
    assign w_pcnt_inc     = r_pcnt + 16'd1;

    always_comb begin
        w_state_d = r_state;
        w_fcnt_d  = (bus.frame && (r_fcnt != 16'hFFFF)) ? r_fcnt + 16'd1 : r_fcnt;
        w_pcnt_d  = r_pcnt;
        w_flash_d = r_flash;
        w_size_d  = r_size;
        unique case (r_state)
            StSetup: begin
                w_size_d = SIZE_MAX;
                if (bus.frame) w_state_d = StReady;
            end
            StReady: begin
                if (w_go_rise) w_state_d = StDrive;
            end
            StDrive: begin
                if (bus.frame) begin
                    if ((r_fcnt >= GraceCnt) && w_crash_now) begin
                        w_state_d = StCrash;
                        w_flash_d = 1'b1;
                    end else if (w_pcnt_inc == ShrinkCnt) begin
                        w_pcnt_d = '0;
                        if (r_size > SIZE_MIN) w_size_d = r_size - 3'd1;
                    end else begin
                        w_pcnt_d = w_pcnt_inc;
                    end
                end
            end
            StCrash: begin
                if (w_go_rise && (r_fcnt >= CrashCnt)) begin
                    w_state_d = StSetup;
                    w_flash_d = 1'b0;
                    w_size_d  = SIZE_MAX;
                end else if (bus.frame) begin
                    if (w_pcnt_inc == FlashCnt) begin
                        w_pcnt_d  = '0;
                        w_flash_d = ~r_flash;
                    end else begin
                        w_pcnt_d = w_pcnt_inc;
                    end
                end
            end
        endcase
        // Any transition wins over a coincident frame pulse: both counters restart.
        if (w_state_d != r_state) begin
            w_fcnt_d = '0;
            w_pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StSetup;
            r_go_q       <= 1'b0;
            r_crash_flag <= 1'b0;
            r_fcnt       <= '0;
            r_pcnt       <= '0;
            r_flash      <= 1'b0;
            r_size       <= SIZE_MAX;
            r_setup      <= 1'b1;
            r_drive      <= 1'b0;
            r_flash_car  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_go_q       <= bus.go;
            r_crash_flag <= w_crash_flag_d;
            r_fcnt       <= w_fcnt_d;
            r_pcnt       <= w_pcnt_d;
            r_flash      <= w_flash_d;
            r_size       <= w_size_d;
            r_setup      <= (w_state_d == StSetup);
            r_drive      <= (w_state_d == StDrive);
            r_flash_car  <= (w_state_d == StCrash);
        end
    end

`ifdef GAME_SCORE_EN
    logic [15:0] r_score;
    logic        w_score_clr, w_score_inc;

    assign w_score_clr = (r_state == StReady) && (w_state_d == StDrive);
    assign w_score_inc = (r_state == StDrive) && bus.frame && (w_state_d == StDrive);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (w_score_clr) begin
            r_score <= '0;
        end else if (w_score_inc && (r_score != 16'hFFFF)) begin
            r_score <= r_score + 16'd1;
        end
    end

    assign bus.score = r_score;
`else
    assign bus.score = 16'd0;
`endif

    assign bus.setup     = r_setup;
    assign bus.drive     = r_drive;
    assign bus.flash     = r_flash;
    assign bus.flash_car = r_flash_car;
    assign bus.size      = r_size;
    assign bus.state_o   = r_state;
endmodule
